// File: rtl/debug_slave_scan_master_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
//   scan_state_e : scan sequencer states (IDLE, UIR, CDR, SDR, UDR)
//   vj_ir_e      : IR codes understood by the Nios II debug slave
//   SrWidthDflt  : default scan register length
//   TckDivDflt   : default clk cycles per tck half-period
package debug_slave_scan_master_pkg;

  localparam int unsigned SrWidthDflt = 38;
  localparam int unsigned TckDivDflt  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr
  } scan_state_e;

  typedef enum logic [1:0] {
    IrOcimem    = 2'd0,
    IrTrace     = 2'd1,
    IrBreak     = 2'd2,
    IrTraceCtrl = 2'd3
  } vj_ir_e;

endpackage

// File: rtl/debug_slave_tck_gen.sv
// Free-running scan clock generator.
// Ports:
//   i_clk, i_reset_n : system clock, asynchronous active-low reset
//   o_tck            : registered scan clock, TCK_DIV clks low then TCK_DIV clks high
//   o_rise           : high in the clk cycle whose closing edge raises o_tck
//   o_fall           : high in the clk cycle whose closing edge drops o_tck (counter wrap)
module debug_slave_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tck,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CntW = (2 * TCK_DIV > 2) ? $clog2(2 * TCK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(2 * TCK_DIV - 1);
  localparam logic [CntW-1:0] CntRise  = CntW'(TCK_DIV - 1);
  localparam logic [CntW-1:0] CntHighF = CntW'(TCK_DIV);

  logic [CntW-1:0] r_div_cnt;
  logic [CntW-1:0] w_div_cnt_d;
  logic            r_tck;

  always_comb begin
    w_div_cnt_d = (r_div_cnt == CntMax) ? '0 : r_div_cnt + 1'b1;
  end

  // tck is registered from the next count so it changes on the same edge as the count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_cnt <= '0;
      r_tck     <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_d;
      r_tck     <= (w_div_cnt_d >= CntHighF);
    end
  end

  assign o_tck  = r_tck;
  assign o_rise = (r_div_cnt == CntRise);
  assign o_fall = (r_div_cnt == CntMax);

endmodule

// File: rtl/debug_slave_scan_master.sv
// Virtual-JTAG initiator for the Nios II debug slave.
// Accepts {cmd_ir, cmd_data}, then runs UIR, CDR, SDR x SR_WIDTH, UDR on a generated tck,
// shifting cmd_data out LSB first on vj_tdi and returning the word captured from vj_tdo.
// Ports:
//   clk, reset_n                 : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          : command handshake (no queueing while busy)
//   cmd_ir, cmd_data             : IR for UIR, data word for SDR
//   rsp_valid                    : one-clk pulse when the scan completes
//   rsp_data                     : captured word, held until the next rsp_valid
//   vj_tck, vj_tdi, vj_tdo       : scan clock and serial data
//   vj_ir_in                     : IR presented to the slave, held after UIR
//   vj_rti, vj_uir, vj_cdr,
//   vj_sdr, vj_udr               : one-hot virtual state strobes
module debug_slave_scan_master
  import debug_slave_scan_master_pkg::*;
#(
  parameter int unsigned SR_WIDTH = SrWidthDflt,
  parameter int unsigned TCK_DIV  = TckDivDflt
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [1:0]          vj_ir_in,
  output logic                vj_rti,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr
);

  localparam int unsigned BitCntW = $clog2(SR_WIDTH + 1);
  localparam logic [BitCntW-1:0] BitCntLast = BitCntW'(SR_WIDTH);

  logic w_rise;
  logic w_fall;

  debug_slave_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .o_tck    (vj_tck),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  scan_state_e         r_state,     w_state_d;
  logic                r_pending,   w_pending_d;
  logic [1:0]          r_ir,        w_ir_d;
  logic [SR_WIDTH-1:0] r_shift,     w_shift_d;
  logic [BitCntW-1:0]  r_bit_cnt,   w_bit_cnt_d;
  logic                r_tdi,       w_tdi_d;
  logic [1:0]          r_ir_in,     w_ir_in_d;
  logic                r_rsp_valid, w_rsp_valid_d;
  logic [SR_WIDTH-1:0] r_rsp_data,  w_rsp_data_d;
  logic                w_accept;

  // Not ready while a response pulse is out, so a command cannot overlap rsp_valid.
  assign cmd_ready = (r_state == StIdle) && !r_pending && !r_rsp_valid;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_state_d     = r_state;
    w_pending_d   = r_pending;
    w_ir_d        = r_ir;
    w_shift_d     = r_shift;
    w_bit_cnt_d   = r_bit_cnt;
    w_tdi_d       = r_tdi;
    w_ir_in_d     = r_ir_in;
    w_rsp_valid_d = 1'b0;
    w_rsp_data_d  = r_rsp_data;

    unique case (r_state)
      StIdle: begin
        // The data word is loaded straight into the shift register; it only moves in SDR.
        if (w_accept) begin
          w_ir_d      = cmd_ir;
          w_shift_d   = cmd_data;
          w_pending_d = 1'b1;
        end
        if (w_fall && (r_pending || w_accept)) begin
          w_state_d   = StUir;
          w_pending_d = 1'b0;
          w_ir_in_d   = w_accept ? cmd_ir : r_ir;
        end
      end
      StUir: begin
        if (w_fall) begin
          w_state_d   = StCdr;
          w_bit_cnt_d = '0;
          w_tdi_d     = r_shift[0];
        end
      end
      StCdr: begin
        if (w_fall) begin
          w_state_d = StSdr;
          w_tdi_d   = r_shift[0];
        end
      end
      StSdr: begin
        if (w_rise) begin
          w_shift_d   = {vj_tdo, r_shift[SR_WIDTH-1:1]};
          w_bit_cnt_d = r_bit_cnt + 1'b1;
        end
        if (w_fall) begin
          if (r_bit_cnt == BitCntLast) begin
            w_state_d = StUdr;
            w_tdi_d   = 1'b0;
          end else begin
            w_tdi_d = r_shift[0];
          end
        end
      end
      StUdr: begin
        if (w_fall) begin
          w_state_d     = StIdle;
          w_rsp_data_d  = r_shift;
          w_rsp_valid_d = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_pending   <= 1'b0;
      r_ir        <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_tdi       <= 1'b0;
      r_ir_in     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pending   <= w_pending_d;
      r_ir        <= w_ir_d;
      r_shift     <= w_shift_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_tdi       <= w_tdi_d;
      r_ir_in     <= w_ir_in_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data  <= w_rsp_data_d;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign vj_tdi    = r_tdi;
  assign vj_ir_in  = r_ir_in;
  assign vj_rti    = (r_state == StIdle);
  assign vj_uir    = (r_state == StUir);
  assign vj_cdr    = (r_state == StCdr);
  assign vj_sdr    = (r_state == StSdr);
  assign vj_udr    = (r_state == StUdr);

endmodule

// File: tb/tb_debug_slave_scan_master.sv
// Bench for debug_slave_scan_master: instance A (TCK_DIV=2) against a loopback slave model,
// instance B (TCK_DIV=1) with tdo tied low. Accepted commands push expectations into a queue;
// per-instance monitors pop and compare on rsp_valid.
module tb_debug_slave_scan_master;
  import debug_slave_scan_master_pkg::*;

  typedef struct {
    logic [37:0] rsp;
    logic [37:0] tdi;
    logic [1:0]  ir;
    int          acc;
  } exp_t;

  localparam logic [37:0] P1 = 38'h15_1234_5678;
  localparam logic [37:0] D0 = 38'h2A_5A5A_A5A5;
  localparam logic [37:0] D1 = 38'h0F_0F0F_0F0F;
  localparam logic [37:0] D2 = 38'h30_F0F0_1234;
  localparam logic [37:0] P3 = 38'h3F_0000_FFFF;
  localparam logic [37:0] D3 = 38'h12_3456_789A;
  localparam logic [37:0] D4 = 38'h2B_CDEF_0123;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Instance A signals
  logic        a_cmd_valid = 1'b0;
  logic        a_cmd_ready;
  logic [1:0]  a_cmd_ir = 2'd0;
  logic [37:0] a_cmd_data = '0;
  logic        a_rsp_valid;
  logic [37:0] a_rsp_data;
  logic        a_tck, a_tdi, a_tdo;
  logic [1:0]  a_ir_in;
  logic        a_rti, a_uir, a_cdr, a_sdr, a_udr;
  logic [37:0] a_exp_rsp = '0;

  // Instance B signals
  logic        b_cmd_valid = 1'b0;
  logic        b_cmd_ready;
  logic [1:0]  b_cmd_ir = 2'd0;
  logic [37:0] b_cmd_data = '0;
  logic        b_rsp_valid;
  logic [37:0] b_rsp_data;
  logic        b_tck, b_tdi;
  logic [1:0]  b_ir_in;
  logic        b_rti, b_uir, b_cdr, b_sdr, b_udr;
  logic [37:0] b_exp_rsp = '0;

  // Slave model for A
  logic        slave_load = 1'b0;
  logic [37:0] slave_pre = '0;
  logic [37:0] slave_reg;
  logic [37:0] a_tdi_cap;
  logic [1:0]  a_ir_seen;
  int          a_sdr_rises;

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, a_n, b_e, b_n;
  int   a_n_uir = 0, a_n_cdr = 0, a_n_sdr = 0, a_n_udr = 0, b_n_sdr = 0;
  int   a_onehot_bad = 0, b_onehot_bad = 0;
  int   a_rsp_seen = 0, b_rsp_seen = 0;
  int   a_last_rsp = -100;

  debug_slave_scan_master #(
    .SR_WIDTH(38),
    .TCK_DIV (2)
  ) u_dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(a_cmd_valid),
    .cmd_ready(a_cmd_ready),
    .cmd_ir   (a_cmd_ir),
    .cmd_data (a_cmd_data),
    .rsp_valid(a_rsp_valid),
    .rsp_data (a_rsp_data),
    .vj_tck   (a_tck),
    .vj_tdi   (a_tdi),
    .vj_tdo   (a_tdo),
    .vj_ir_in (a_ir_in),
    .vj_rti   (a_rti),
    .vj_uir   (a_uir),
    .vj_cdr   (a_cdr),
    .vj_sdr   (a_sdr),
    .vj_udr   (a_udr)
  );

  debug_slave_scan_master #(
    .SR_WIDTH(38),
    .TCK_DIV (1)
  ) u_dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(b_cmd_valid),
    .cmd_ready(b_cmd_ready),
    .cmd_ir   (b_cmd_ir),
    .cmd_data (b_cmd_data),
    .rsp_valid(b_rsp_valid),
    .rsp_data (b_rsp_data),
    .vj_tck   (b_tck),
    .vj_tdi   (b_tdi),
    .vj_tdo   (1'b0),
    .vj_ir_in (b_ir_in),
    .vj_rti   (b_rti),
    .vj_uir   (b_uir),
    .vj_cdr   (b_cdr),
    .vj_sdr   (b_sdr),
    .vj_udr   (b_udr)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Loopback slave: tdo is the register LSB, tdi enters at the MSB on each SDR rise.
  assign a_tdo = slave_reg[0];
  always @(posedge a_tck or posedge slave_load) begin
    if (slave_load) begin
      slave_reg <= slave_pre;
    end else begin
      if (a_uir) a_ir_seen <= a_ir_in;
      if (a_cdr) begin
        a_tdi_cap   <= '0;
        a_sdr_rises <= 0;
      end
      if (a_sdr) begin
        slave_reg   <= {a_tdi, slave_reg[37:1]};
        a_tdi_cap   <= {a_tdi, a_tdi_cap[37:1]};
        a_sdr_rises <= a_sdr_rises + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_tests++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Monitor A: protocol sampling on the falling clk edge.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      a_n_uir = 0; a_n_cdr = 0; a_n_sdr = 0; a_n_udr = 0;
    end else begin
      if ($countones({a_rti, a_uir, a_cdr, a_sdr, a_udr}) != 1) a_onehot_bad++;
      if (a_uir) a_n_uir++;
      if (a_cdr) a_n_cdr++;
      if (a_sdr) a_n_sdr++;
      if (a_udr) a_n_udr++;
      if (a_rsp_valid) begin
        a_rsp_seen++;
        a_last_rsp = cyc;
        check("a_ready_during_rsp", 64'(a_cmd_ready), 64'd0);
        if (a_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_unexpected_rsp: got rsp_valid data %0h, required none", a_rsp_data);
        end else begin
          a_e = a_q.pop_front();
          check("a_rsp_data", a_rsp_data, a_e.rsp);
          check("a_tdi_sequence", a_tdi_cap, a_e.tdi);
          check("a_ir_during_uir", a_ir_seen, a_e.ir);
          check("a_ir_in_held", a_ir_in, a_e.ir);
          check_range("a_latency", cyc - a_e.acc, 165, 168);
          check("a_uir_clks", a_n_uir, 4);
          check("a_cdr_clks", a_n_cdr, 4);
          check("a_sdr_clks", a_n_sdr, 152);
          check("a_udr_clks", a_n_udr, 4);
        end
        a_n_uir = 0; a_n_cdr = 0; a_n_sdr = 0; a_n_udr = 0;
      end
      if (a_cmd_valid && a_cmd_ready) begin
        a_n.rsp = a_exp_rsp;
        a_n.tdi = a_cmd_data;
        a_n.ir  = a_cmd_ir;
        a_n.acc = cyc;
        a_q.push_back(a_n);
      end
    end
  end

  // Monitor B
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      b_n_sdr = 0;
    end else begin
      if ($countones({b_rti, b_uir, b_cdr, b_sdr, b_udr}) != 1) b_onehot_bad++;
      if (b_sdr) b_n_sdr++;
      if (b_rsp_valid) begin
        b_rsp_seen++;
        if (b_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_unexpected_rsp: got rsp_valid data %0h, required none", b_rsp_data);
        end else begin
          b_e = b_q.pop_front();
          check("b_rsp_data", b_rsp_data, b_e.rsp);
          check("b_ir_in_held", b_ir_in, b_e.ir);
          check_range("b_latency", cyc - b_e.acc, 83, 84);
          check("b_sdr_clks", b_n_sdr, 76);
        end
        b_n_sdr = 0;
      end
      if (b_cmd_valid && b_cmd_ready) begin
        b_n.rsp = b_exp_rsp;
        b_n.tdi = b_cmd_data;
        b_n.ir  = b_cmd_ir;
        b_n.acc = cyc;
        b_q.push_back(b_n);
      end
    end
  end

  task automatic load_slave(input logic [37:0] v);
    slave_pre  = v;
    slave_load = 1'b1;
    #1;
    slave_load = 1'b0;
  endtask

  task automatic wait_ready_a(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (a_cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: cmd_ready got 0 for 600 clks, required 1", name);
    end
  endtask

  task automatic send_a(input logic [1:0] ir, input logic [37:0] data, input logic [37:0] rsp);
    a_cmd_ir    = ir;
    a_cmd_data  = data;
    a_exp_rsp   = rsp;
    a_cmd_valid = 1'b1;
    wait_ready_a("a_accept");
    @(posedge clk);
    #1;
    a_cmd_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 600 && a_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("a_drain_pending", a_q.size(), 0);
  endtask

  int   sa[17];
  int   sb[17];
  int   bad_a, bad_b, rsp_base, acc2;
  logic [37:0] ones38;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Idle after reset
    repeat (20) @(negedge clk);
    check("idle_rti", a_rti, 1);
    check("idle_strobes", {a_uir, a_cdr, a_sdr, a_udr}, 0);
    check("idle_cmd_ready", a_cmd_ready, 1);
    check("idle_tdi", a_tdi, 0);
    check("idle_ir_in", a_ir_in, 0);
    check("idle_rsp", {a_rsp_valid, a_rsp_data}, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      sa[i] = int'(a_tck);
      sb[i] = int'(b_tck);
    end
    bad_a = 0;
    bad_b = 0;
    for (int i = 0; i < 15; i++) if (sa[i] == sa[i+2]) bad_a++;
    for (int i = 0; i < 16; i++) if (sb[i] == sb[i+1]) bad_b++;
    check("a_tck_toggle_every_2", bad_a, 0);
    check("b_tck_toggle_every_1", bad_b, 0);

    // Loopback scan
    @(posedge clk);
    #1;
    load_slave(P1);
    send_a(IrBreak, D0, P1);
    drain_a();
    check("a_tdi_idle_after_scan", a_tdi, 0);
    check("slave_holds_cmd_data", slave_reg, D0);

    // cmd_valid held through a scan, second command follows
    rsp_base    = a_rsp_seen;
    a_cmd_ir    = IrTrace;
    a_cmd_data  = D1;
    a_exp_rsp   = D0;
    a_cmd_valid = 1'b1;
    wait_ready_a("b2b_first_accept");
    @(posedge clk);
    #1;
    a_cmd_ir   = IrTraceCtrl;
    a_cmd_data = D2;
    a_exp_rsp  = D1;
    wait_ready_a("b2b_second_accept");
    acc2 = cyc;
    check("b2b_accept_after_rsp", acc2, a_last_rsp + 1);
    @(posedge clk);
    #1;
    a_cmd_valid = 1'b0;
    drain_a();
    check("b2b_rsp_count", a_rsp_seen - rsp_base, 2);

    // Reset in the middle of SDR
    load_slave(P3);
    send_a(IrOcimem, D3, P3);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (a_sdr && a_sdr_rises == 17) begin
          hit = 1'b1;
          break;
        end
      end
      n_tests++;
      if (!hit) begin
        n_fail++;
        $display("FAIL reach_sdr_bit17: got %0d SDR rises, required 17", a_sdr_rises);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    a_q.delete();
    #1;
    check("rst_rti", a_rti, 1);
    check("rst_strobes", {a_uir, a_cdr, a_sdr, a_udr}, 0);
    check("rst_tck_tdi", {a_tck, a_tdi}, 0);
    check("rst_ir_in", a_ir_in, 0);
    check("rst_rsp", {a_rsp_valid, a_rsp_data}, 0);
    check("rst_cmd_ready", a_cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    load_slave(P3);
    send_a(IrTraceCtrl, D4, P3);
    drain_a();

    // TCK_DIV=1 instance, all-ones word with tdo low
    ones38      = '1;
    b_cmd_ir    = IrTrace;
    b_cmd_data  = ones38;
    b_exp_rsp   = '0;
    b_cmd_valid = 1'b1;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (b_cmd_ready) begin
          ok = 1'b1;
          break;
        end
      end
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL b_accept: cmd_ready got 0 for 200 clks, required 1");
      end
    end
    @(posedge clk);
    #1;
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 300 && b_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("b_drain_pending", b_q.size(), 0);
    check("b_rsp_count", b_rsp_seen, 1);

    check("a_strobes_onehot", a_onehot_bad, 0);
    check("b_strobes_onehot", b_onehot_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_slave_scan_master.md
Name: debug_slave_scan_master

Overview:
- Drives the virtual-JTAG side of a Nios II debug slave from system logic. It acts as the initiator that the debug slave's TCK-domain shift register responds to.
- Accepts a command consisting of a 2-bit IR and a 38-bit data word, then sequences UIR, CDR, SDR×38 and UDR on a generated tck.
- Shifts the data word out on tdi, captures tdo, and returns the captured 38-bit word.
- Used for on-chip debug bring-up benches and for self-hosted debug of the multicore CPUs without a JTAG cable.

Parameters:
- SR_WIDTH, 38, scan register length (number of SDR shift periods).
- TCK_DIV, 2, clk cycles per tck half-period; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and accepts a command this cycle.
- cmd_ir  in  2  IR value presented during UIR.
- cmd_data  in  SR_WIDTH  word shifted out on tdi, LSB first.
- rsp_valid  out  1  one-cycle pulse: scan complete.
- rsp_data  out  SR_WIDTH  captured tdo word; held until the next rsp_valid.
- vj_tck  out  1  generated scan clock.
- vj_tdi  out  1  serial data to the slave.
- vj_tdo  in  1  serial data from the slave.
- vj_ir_in  out  2  IR presented to the slave.
- vj_rti  out  1  run-test-idle indication.
- vj_uir, vj_cdr, vj_sdr, vj_udr  out  1 each  one-hot virtual state strobes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - state=IDLE, div_cnt=0, vj_tck=0, vj_tdi=0, vj_ir_in=0.
  - Strobes all 0, vj_rti=1, cmd_ready=1, rsp_valid=0, rsp_data=0.
- tck generation:
  - div_cnt counts 0..2*TCK_DIV-1 continuously and wraps.
  - vj_tck = (div_cnt >= TCK_DIV), registered; tck is free-running.
  - rise event: the cycle in which div_cnt becomes TCK_DIV.
  - fall event: the cycle in which div_cnt wraps to 0.
- Timing rules:
  - All scan outputs (strobes, vj_tdi, vj_ir_in) change only on fall events.
  - vj_tdo is sampled only on rise events.
- States and transitions, all on fall events:
  - IDLE: vj_rti=1, cmd_ready=1. On a clk cycle with cmd_valid&cmd_ready, latch cmd_ir/cmd_data and set a pending flag; cmd_ready drops the next cycle. At the next fall event go to UIR.
  - UIR: vj_uir=1, vj_ir_in=latched IR, held for 1 tck period. Then go to CDR.
  - CDR: vj_cdr=1 for 1 period. shift=latched data, bit_cnt=0, vj_tdi=shift[0]. Then go to SDR.
  - SDR: vj_sdr=1.
    - Each rise event: shift <= {vj_tdo, shift[SR_WIDTH-1:1]}, bit_cnt++.
    - Each fall event: vj_tdi=shift[0].
    - Leave after the fall event following the SR_WIDTH-th rise, i.e. exactly SR_WIDTH periods, then go to UDR.
  - UDR: vj_udr=1 for 1 period. At its closing fall event: rsp_data<=shift, rsp_valid=1 for one clk, state=IDLE.
- Latency: from accept to rsp_valid = wait to next fall (1..2*TCK_DIV clks) + (SR_WIDTH+3)*2*TCK_DIV clks. With defaults: 164 clks plus the wait.
- Boundary conditions:
  - vj_ir_in holds its value after UIR until the next command.
  - vj_tdi returns to 0 in IDLE.
  - cmd_valid while busy is ignored; no queueing.
  - A cmd_valid in the same cycle as rsp_valid is not accepted. cmd_ready re-asserts the cycle after rsp_valid.
  - Reset mid-scan: immediate return to reset values; no rsp_valid; rsp_data cleared.
  - Strobes are mutually exclusive at all times. Exactly one of vj_rti/uir/cdr/sdr/udr is 1.

Decomposition:
- Shared package: state enum (IDLE, UIR, CDR, SDR, UDR), SR_WIDTH default, IR codes.
  - IR codes: 0 ocimem, 1 trace, 2 break, 3 tracectrl.
- One natural sub-module: debug_slave_tck_gen (div_cnt, vj_tck, rise/fall event pulses).

Test Plan:
- Reset then idle 20 clks -> vj_rti=1, strobes 0, cmd_ready=1, vj_tck toggles every 2 clks.
- cmd_ir=2, cmd_data=38'h2A_5A5A_A5A5, slave model loops tdi to tdo through a 38-bit register preloaded with 38'h15_1234_5678 -> vj_ir_in=2 during UIR; tdi bit sequence equals cmd_data LSB-first; rsp_data=38'h15_1234_5678.
- Count strobe periods -> UIR 1, CDR 1, SDR exactly 38, UDR 1 tck periods. Accept-to-rsp_valid = 164 + wait clks (≤168).
- cmd_valid held high through the scan plus a second command -> second command is accepted only the cycle after rsp_valid; exactly two rsp_valid pulses.
- reset_n low at SDR bit 17 -> outputs at reset values asynchronously, no rsp_valid; a new command afterwards completes correctly.
- TCK_DIV=1, all-ones data with tdo tied 0 -> rsp_data=0, tck period 2 clks, total latency (38+3)*2 = 82 clks plus the wait.
